// File: rtl/ahb_gpio.sv
// AHB-Lite slave for a 16-bit GPIO port with a parity bit: a direction register,
// an output data register with generated parity, and a sampled, parity-checked input.
module ahb_gpio (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    output logic        HREADYOUT,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    input  logic [16:0] GPIOIN,
    output logic [16:0] GPIOOUT,
    output logic        PARITYERR,
    input  logic        PARITYSEL
);

    localparam logic [7:0] ADDR_DATA = 8'h00;
    localparam logic [7:0] ADDR_DIR  = 8'h04;

    logic [7:0]  addr_q;
    logic        write_q;
    logic        valid_q;
    logic [15:0] out_q;
    logic [15:0] in_q;
    logic        dir_q;
    logic        perr_q;
    logic        phase_ok;
    logic        in_err;
    logic        unused_bits;

    assign phase_ok = HSEL & HREADY & HTRANS[1];

    // Total parity of the 17-bit input word differs from the selected mode.
    assign in_err = (^GPIOIN) ^ PARITYSEL;

    assign unused_bits = ^{HADDR[31:8], HTRANS[0], HWDATA[31:16]};

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            addr_q  <= 8'h00;
            write_q <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= 16'h0000;
            in_q    <= 16'h0000;
            dir_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            valid_q <= phase_ok;
            if (phase_ok) begin
                addr_q  <= HADDR[7:0];
                write_q <= HWRITE;
            end

            // Data-phase write; a DATA write only lands while the port drives outputs.
            if (valid_q && write_q) begin
                if (addr_q == ADDR_DIR) begin
                    dir_q <= HWDATA[0];
                end else if ((addr_q == ADDR_DATA) && dir_q) begin
                    out_q <= HWDATA[15:0];
                end
            end

            if (!dir_q) begin
                in_q   <= GPIOIN[15:0];
                perr_q <= in_err;
            end else begin
                perr_q <= 1'b0;
            end
        end
    end

    always_comb begin
        HRDATA = 32'h0000_0000;
        if (valid_q && !write_q) begin
            case (addr_q)
                ADDR_DATA: HRDATA = {16'h0000, in_q};
                ADDR_DIR:  HRDATA = {31'h0, dir_q};
                default:   HRDATA = 32'h0000_0000;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign GPIOOUT   = {(^out_q) ^ PARITYSEL, out_q};
    // Masked so the flag drops in the same cycle the port turns to output mode.
    assign PARITYERR = perr_q & ~dir_q;

endmodule

// File: tb/tb_ahb_gpio.sv
// Scoreboard bench for ahb_gpio: stimulus advances a register-level model each cycle and
// queues the expected outputs; a monitor pops one entry per cycle and compares.
module tb_ahb_gpio;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic [16:0] GPIOIN;
    logic [16:0] GPIOOUT;
    logic        PARITYERR;
    logic        PARITYSEL;

    ahb_gpio dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .GPIOIN    (GPIOIN),
        .GPIOOUT   (GPIOOUT),
        .PARITYERR (PARITYERR),
        .PARITYSEL (PARITYSEL)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        chk_rd;
        logic [31:0] hrdata;
        logic [16:0] gpioout;
        logic        perr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Register-level reference state.
    logic        m_dir  = 1'b0;
    logic [15:0] m_out  = 16'h0;
    logic [15:0] m_in   = 16'h0;
    logic        m_perr = 1'b0;
    logic        ph_valid = 1'b0;
    logic        ph_write = 1'b0;
    logic [7:0]  ph_addr  = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Parity bit that gives the 17-bit word the selected total parity.
    function automatic logic par_bit(input logic [15:0] d, input logic odd);
        return (($countones(d) % 2) == 1) ^ odd;
    endfunction

    // One clock: compute next model state from the driven inputs, step, queue expectations.
    task automatic tick();
        logic        nv, nw, n_dir, n_perr;
        logic [7:0]  na;
        logic [15:0] n_out, n_in;
        exp_t        e;
        nv    = HSEL && HREADY && HTRANS[1];
        nw    = HWRITE;
        na    = HADDR[7:0];
        n_dir = m_dir;
        n_out = m_out;
        if (ph_valid && ph_write) begin
            if (ph_addr == 8'h04) n_dir = HWDATA[0];
            else if (ph_addr == 8'h00 && m_dir) n_out = HWDATA[15:0];
        end
        n_in   = m_dir ? m_in : GPIOIN[15:0];
        n_perr = m_dir ? 1'b0 : ((($countones(GPIOIN) % 2) == 1) != PARITYSEL);
        if (!HRESETn) begin
            nv = 1'b0; nw = 1'b0; na = 8'h00;
            n_dir = 1'b0; n_out = 16'h0; n_in = 16'h0; n_perr = 1'b0;
        end
        @(posedge HCLK);
        ph_valid = nv; ph_write = nw; ph_addr = na;
        m_dir = n_dir; m_out = n_out; m_in = n_in; m_perr = n_perr;
        e.chk_rd = !(ph_valid && ph_write);
        e.hrdata = 32'h0;
        if (ph_valid && !ph_write) begin
            if (ph_addr == 8'h00) e.hrdata = {16'h0, m_in};
            else if (ph_addr == 8'h04) e.hrdata = {31'h0, m_dir};
        end
        e.gpioout = {par_bit(m_out, PARITYSEL), m_out};
        e.perr    = m_dir ? 1'b0 : m_perr;
        exp_q.push_back(e);
        @(negedge HCLK);
        #1;
    endtask

    // Monitor: the slave presents a response every cycle (zero wait states).
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_rd) check("hrdata", HRDATA, e.hrdata);
                check("gpioout", {15'h0, GPIOOUT}, {15'h0, e.gpioout});
                check("parityerr", {31'h0, PARITYERR}, {31'h0, e.perr});
                check("hreadyout", {31'h0, HREADYOUT}, 32'h1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = 32'h0;
    endtask

    task automatic addr_phase(input logic [7:0] a, input logic w);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = w;
        HREADY = 1'b1;
        HADDR  = {24'h0, a};
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
        addr_phase(a, 1'b1);
        tick();
        idle();
        HWDATA = {16'hDEAD, d};
        tick();
    endtask

    task automatic bus_read(input logic [7:0] a);
        addr_phase(a, 1'b0);
        tick();
        idle();
        tick();
    endtask

    initial begin
        logic [7:0] a;
        HRESETn = 1'b0;
        idle();
        HREADY    = 1'b1;
        HWDATA    = 32'h0;
        GPIOIN    = 17'h0;
        PARITYSEL = 1'b0;
        tick();
        tick();
        HRESETn = 1'b1;
        tick();
        bus_read(8'h00);
        bus_read(8'h04);

        // Pipelined DIR then DATA write; DATA must see the new direction.
        addr_phase(8'h04, 1'b1);
        tick();
        addr_phase(8'h00, 1'b1);
        HWDATA = 32'h1;
        tick();
        idle();
        HWDATA = 32'h0000_1234;
        tick();
        tick();
        PARITYSEL = 1'b1;
        tick();
        bus_read(8'h04);
        PARITYSEL = 1'b0;

        // Input mode: sampling, readback and parity errors.
        bus_write(8'h04, 16'h0000);
        GPIOIN = {1'b0, 16'hA5A5};
        tick();
        bus_read(8'h00);
        GPIOIN = {1'b1, 16'hA5A5};
        tick();
        tick();
        GPIOIN = {1'b0, 16'hA5A5};
        tick();
        tick();
        PARITYSEL = 1'b1;
        tick();
        tick();
        PARITYSEL = 1'b0;

        // DATA write ignored while in input mode.
        bus_write(8'h00, 16'hFFFF);
        tick();

        // Reset during the data phase discards the pending DIR write.
        addr_phase(8'h04, 1'b1);
        tick();
        idle();
        HWDATA  = 32'h1;
        HRESETn = 1'b0;
        tick();
        HRESETn = 1'b1;
        tick();
        bus_read(8'h04);

        // Unselected and BUSY transfers change nothing.
        HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h4;
        tick();
        idle();
        HWDATA = 32'h1;
        tick();
        HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 32'h4;
        tick();
        idle();
        HWDATA = 32'h1;
        tick();
        bus_read(8'h04);

        // Randomized per-cycle bus and port activity.
        for (int i = 0; i < 400; i++) begin
            HRESETn = ($urandom_range(0, 63) != 0);
            HSEL    = ($urandom_range(0, 3) != 0);
            HTRANS  = 2'($urandom);
            HWRITE  = 1'($urandom);
            HREADY  = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0:       a = 8'h00;
                1:       a = 8'h04;
                2:       a = 8'h08;
                default: a = 8'($urandom);
            endcase
            HADDR  = {24'($urandom), a};
            HWDATA = $urandom;
            GPIOIN = 17'($urandom);
            if ($urandom_range(0, 3) == 0) PARITYSEL = ~PARITYSEL;
            tick();
        end

        HRESETn = 1'b1;
        idle();
        tick();
        tick();
        check("queue_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
